regfile_fall: RTL and testbench



---
 rtl/regfile_fall.sv | 89 ++++++++
 tb/tb_regfile_fall.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_fall.sv
// Multi-port register file for the 5-stage pipeline.
// One write port on the falling clock edge, two combinational read ports.
`timescale 1ns/10ps
module regfile_fall #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic wr_drop;
    logic wr_fire;
    logic byp_a;
    logic byp_b;

    // Qualify the write: entry 0 swallows writes when hardwired to zero
    always_comb begin
        wr_drop = (ZERO_REG != 0) && (waddr == '0);
        wr_fire = we && !wr_drop;
    end

    // Next array state: hold everything, update the addressed entry
    always_comb begin
        mem_d = mem_q;
        if (wr_fire) begin
            mem_d[waddr] = wdata;
        end
        if (ZERO_REG != 0) begin
            mem_d[0] = '0;
        end
    end

    // Falling-edge storage; clr low clears the whole array at once
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Same-cycle forwarding of the pending write when enabled
    always_comb begin
        byp_a = (BYPASS != 0) && we && clr && !wr_drop
                && (raddr_a == waddr);
        byp_b = (BYPASS != 0) && we && clr && !wr_drop
                && (raddr_b == waddr);
    end

    // Read port A; forced to zero while held in reset
    always_comb begin
        if (!clr) begin
            rdata_a = '0;
        end else if (byp_a) begin
            rdata_a = wdata;
        end else begin
            rdata_a = mem_q[raddr_a];
        end
    end

    // Read port B; forced to zero while held in reset
    always_comb begin
        if (!clr) begin
            rdata_b = '0;
        end else if (byp_b) begin
            rdata_b = wdata;
        end else begin
            rdata_b = mem_q[raddr_b];
        end
    end

endmodule

// File: tb/tb_regfile_fall.sv
// Directed bench for regfile_fall.
// Three parameter sets share one stimulus stream.
`timescale 1ns/10ps
module tb_regfile_fall;

    logic        clk;
    logic        clr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;

    logic [31:0] rd_a_z;
    logic [31:0] rd_b_z;
    logic [31:0] rd_a_nb;
    logic [31:0] rd_b_nb;
    logic [31:0] rd_a_zb;
    logic [31:0] rd_b_zb;

    int n_checks;
    int n_errors;

    // ZERO_REG=1, BYPASS=0
    regfile_fall #(
        .WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)
    ) dut (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr_a(raddr_a), .rdata_a(rd_a_z),
        .raddr_b(raddr_b), .rdata_b(rd_b_z)
    );

    // ZERO_REG=0, BYPASS=1
    regfile_fall #(
        .WIDTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)
    ) dut_nb (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr_a(raddr_a), .rdata_a(rd_a_nb),
        .raddr_b(raddr_b), .rdata_b(rd_b_nb)
    );

    // ZERO_REG=1, BYPASS=1
    regfile_fall #(
        .WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
    ) dut_zb (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr_a(raddr_a), .rdata_a(rd_a_zb),
        .raddr_b(raddr_b), .rdata_b(rd_b_zb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [4:0] a,
                              input logic [31:0] d);
        @(posedge clk);
        #1;
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(negedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clr      = 1'b0;
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        raddr_a  = 5'd0;
        raddr_b  = 5'd0;

        #2;
        check("reset_a", rd_a_z, 32'h0);
        check("reset_b", rd_b_z, 32'h0);
        #1 clr = 1'b1;

        // fill 1..31 then clear asynchronously
        for (int i = 1; i < 32; i++) begin
            write_word(5'(i), 32'hDEADBEEF);
        end
        raddr_a = 5'd31;
        raddr_b = 5'd1;
        #1;
        check("fill_31", rd_a_z, 32'hDEADBEEF);
        check("fill_1", rd_b_nb, 32'hDEADBEEF);

        @(posedge clk);
        #1 clr = 1'b0;
        for (int i = 1; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(i);
            #0.05;
            check("clr_a", rd_a_z, 32'h0);
            check("clr_b", rd_b_nb, 32'h0);
        end
        #0.45 clr = 1'b1;
        #0.05;
        raddr_a = 5'd20;
        #0.05;
        check("clr_hold", rd_a_nb, 32'h0);

        // falling-edge write visible in second half
        @(posedge clk);
        #1;
        raddr_a = 5'd5;
        we      = 1'b1;
        waddr   = 5'd5;
        wdata   = 32'h12345678;
        #2;
        check("fe_before", rd_a_z, 32'h0);
        @(negedge clk);
        #1;
        check("fe_after", rd_a_z, 32'h12345678);
        we = 1'b0;

        // zero register
        write_word(5'd0, 32'hFFFFFFFF);
        raddr_a = 5'd0;
        raddr_b = 5'd0;
        #1;
        check("zr_a", rd_a_z, 32'h0);
        check("zr_b", rd_b_z, 32'h0);
        check("nzr_a", rd_a_nb, 32'hFFFFFFFF);

        // dual read and hold
        write_word(5'd3, 32'hA);
        write_word(5'd7, 32'hB);
        raddr_a = 5'd3;
        raddr_b = 5'd7;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #3;
            check("hold_a", rd_a_z, 32'hA);
            check("hold_b", rd_b_z, 32'hB);
        end
        raddr_a = 5'd7;
        #1;
        check("same_a", rd_a_z, 32'hB);
        check("same_b", rd_b_z, 32'hB);

        // reset beats write
        @(posedge clk);
        #1;
        clr     = 1'b0;
        we      = 1'b1;
        waddr   = 5'd9;
        wdata   = 32'h55;
        raddr_a = 5'd9;
        #1;
        check("rw_byp_rst", rd_a_nb, 32'h0);
        @(negedge clk);
        #1;
        we = 1'b0;
        #1 clr = 1'b1;
        #1;
        check("rw_e9", rd_a_z, 32'h0);
        check("rw_e9_nb", rd_a_nb, 32'h0);

        // bypass before the falling edge
        @(posedge clk);
        #1;
        we      = 1'b1;
        waddr   = 5'd12;
        raddr_a = 5'd12;
        wdata   = 32'h77;
        #1;
        check("byp_nb", rd_a_nb, 32'h77);
        check("byp_zb", rd_a_zb, 32'h77);
        check("nobyp", rd_a_z, 32'h0);
        @(negedge clk);
        #1;
        check("byp_commit", rd_a_z, 32'h77);
        we = 1'b0;

        @(posedge clk);
        #1;
        we      = 1'b1;
        waddr   = 5'd0;
        raddr_a = 5'd0;
        wdata   = 32'h99;
        #1;
        check("byp_zr", rd_a_zb, 32'h0);
        check("byp_r0", rd_a_nb, 32'h99);
        @(negedge clk);
        #1;
        check("byp_zr_post", rd_a_zb, 32'h0);
        we = 1'b0;

        #10;
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
